// File: rtl/register_file_pkg.sv
// Shared definitions for the register file: default geometry, reset values of the
// configuration registers, and the architectural indices of the exported registers.
package register_file_pkg;

  localparam int REG_WIDTH_DEF  = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  localparam logic [7:0] REG2_RST = 8'h81;
  localparam logic [7:0] REG3_RST = 8'h20;

  typedef enum logic [1:0] {
    ALU_A     = 2'd0,
    ALU_B     = 2'd1,
    UART_CFG  = 2'd2,
    DIV_RATIO = 2'd3
  } reg_idx_e;

  // Reset image of one entry: only the UART and divider configuration are nonzero.
  function automatic logic [7:0] reset_value(input int idx);
    logic [7:0] val_s;
    case (idx)
      int'(UART_CFG):  val_s = REG2_RST;
      int'(DIV_RATIO): val_s = REG3_RST;
      default:         val_s = 8'h00;
    endcase
    return val_s;
  endfunction

endpackage

// File: rtl/register_file.sv
// Single-port register file with registered read data and a one-cycle valid strobe;
// entries 0..3 are also exported continuously to the datapath.
module register_file
  import register_file_pkg::*;
#(
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RdEn,
  input  logic                  WrEn,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [REG_WIDTH-1:0]  WrData,
  output logic [REG_WIDTH-1:0]  RdData,
  output logic                  RdData_Valid,
  output logic [REG_WIDTH-1:0]  REG0,
  output logic [REG_WIDTH-1:0]  REG1,
  output logic [REG_WIDTH-1:0]  REG2,
  output logic [REG_WIDTH-1:0]  REG3
);

  localparam int FILE_DEPTH = 2 ** ADDR_WIDTH;

  logic [REG_WIDTH-1:0] mem_r [FILE_DEPTH];
  logic [REG_WIDTH-1:0] rd_data_r;
  logic                 rd_valid_r;
  logic                 wr_req_s;
  logic                 rd_req_s;

  // Simultaneous read and write is illegal and is treated as a no-op.
  assign wr_req_s = WrEn & ~RdEn;
  assign rd_req_s = RdEn & ~WrEn;

  // Storage array: async clear to the reset image, single write port.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < FILE_DEPTH; i++) begin
        mem_r[i] <= REG_WIDTH'(reset_value(i));
      end
    end else if (wr_req_s) begin
      mem_r[Address] <= WrData;
    end
  end

  // Read port: data holds between reads, valid pulses once per accepted read.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data_r  <= {REG_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else if (rd_req_s) begin
      rd_data_r  <= mem_r[Address];
      rd_valid_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign RdData       = rd_data_r;
  assign RdData_Valid = rd_valid_r;

  assign REG0 = mem_r[ADDR_WIDTH'(ALU_A)];
  assign REG1 = mem_r[ADDR_WIDTH'(ALU_B)];
  assign REG2 = mem_r[ADDR_WIDTH'(UART_CFG)];
  assign REG3 = mem_r[ADDR_WIDTH'(DIV_RATIO)];

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file, plus a hand-written async-reset sequence.
module tb_register_file;

  logic       CLK;
  logic       RST;
  logic       RdEn;
  logic       WrEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic [7:0] REG0, REG1, REG2, REG3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_valid;
    logic [7:0] exp_r0;
    logic [7:0] exp_r1;
    logic [7:0] exp_r2;
    logic [7:0] exp_r3;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  register_file dut (
    .CLK(CLK), .RST(RST), .RdEn(RdEn), .WrEn(WrEn), .Address(Address),
    .WrData(WrData), .RdData(RdData), .RdData_Valid(RdData_Valid),
    .REG0(REG0), .REG1(REG1), .REG2(REG2), .REG3(REG3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, " REG0"}, REG0, e0);
    chk({tag, " REG1"}, REG1, e1);
    chk({tag, " REG2"}, REG2, e2);
    chk({tag, " REG3"}, REG3, e3);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] a,
                              input logic [7:0] wd, input logic [7:0] rdat, input logic v,
                              input logic [7:0] r0, input logic [7:0] r1,
                              input logic [7:0] r2, input logic [7:0] r3);
    vec_t t;
    t.rd = rd; t.wr = wr; t.addr = a; t.wdata = wd;
    t.exp_rdata = rdat; t.exp_valid = v;
    t.exp_r0 = r0; t.exp_r1 = r1; t.exp_r2 = r2; t.exp_r3 = r3;
    return t;
  endfunction

  initial begin
    //              rd    wr    addr   wdata  rdata  vld   REG0   REG1   REG2   REG3
    vecs[0]  = mk(1'b1, 1'b0, 4'd5,  8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h81, 8'h20);
    vecs[1]  = mk(1'b0, 1'b1, 4'd1,  8'd15, 8'h00, 1'b0, 8'h00, 8'h0F, 8'h81, 8'h20);
    vecs[2]  = mk(1'b0, 1'b1, 4'd1,  8'd5,  8'h00, 1'b0, 8'h00, 8'h05, 8'h81, 8'h20);
    vecs[3]  = mk(1'b0, 1'b1, 4'd7,  8'd100,8'h00, 1'b0, 8'h00, 8'h05, 8'h81, 8'h20);
    vecs[4]  = mk(1'b1, 1'b0, 4'd7,  8'h00, 8'h64, 1'b1, 8'h00, 8'h05, 8'h81, 8'h20);
    vecs[5]  = mk(1'b0, 1'b0, 4'd7,  8'h00, 8'h64, 1'b0, 8'h00, 8'h05, 8'h81, 8'h20);
    vecs[6]  = mk(1'b0, 1'b1, 4'd10, 8'd200,8'h64, 1'b0, 8'h00, 8'h05, 8'h81, 8'h20);
    vecs[7]  = mk(1'b1, 1'b0, 4'd10, 8'h00, 8'hC8, 1'b1, 8'h00, 8'h05, 8'h81, 8'h20);
    vecs[8]  = mk(1'b1, 1'b0, 4'd1,  8'h00, 8'h05, 1'b1, 8'h00, 8'h05, 8'h81, 8'h20);
    vecs[9]  = mk(1'b1, 1'b1, 4'd3,  8'hFF, 8'h05, 1'b0, 8'h00, 8'h05, 8'h81, 8'h20);
    vecs[10] = mk(1'b1, 1'b0, 4'd3,  8'h00, 8'h20, 1'b1, 8'h00, 8'h05, 8'h81, 8'h20);
    vecs[11] = mk(1'b0, 1'b1, 4'd0,  8'hAA, 8'h20, 1'b0, 8'hAA, 8'h05, 8'h81, 8'h20);
    vecs[12] = mk(1'b0, 1'b1, 4'd2,  8'h3C, 8'h20, 1'b0, 8'hAA, 8'h05, 8'h3C, 8'h20);
    vecs[13] = mk(1'b0, 1'b1, 4'd15, 8'h5A, 8'h20, 1'b0, 8'hAA, 8'h05, 8'h3C, 8'h20);
    vecs[14] = mk(1'b1, 1'b0, 4'd15, 8'h00, 8'h5A, 1'b1, 8'hAA, 8'h05, 8'h3C, 8'h20);
    vecs[15] = mk(1'b0, 1'b1, 4'd3,  8'h11, 8'h5A, 1'b0, 8'hAA, 8'h05, 8'h3C, 8'h11);
    vecs[16] = mk(1'b1, 1'b0, 4'd0,  8'h00, 8'hAA, 1'b1, 8'hAA, 8'h05, 8'h3C, 8'h11);

    RST = 1'b0; RdEn = 1'b0; WrEn = 1'b0; Address = 4'd0; WrData = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset RdData", RdData, 8'h00);
    chk("reset Valid", {7'd0, RdData_Valid}, 8'h00);
    chk_regs("reset", 8'h00, 8'h00, 8'h81, 8'h20);

    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      RdEn = vecs[i].rd; WrEn = vecs[i].wr; Address = vecs[i].addr; WrData = vecs[i].wdata;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d RdData", i), RdData, vecs[i].exp_rdata);
      chk($sformatf("vec%0d Valid", i), {7'd0, RdData_Valid}, {7'd0, vecs[i].exp_valid});
      chk_regs($sformatf("vec%0d", i), vecs[i].exp_r0, vecs[i].exp_r1,
               vecs[i].exp_r2, vecs[i].exp_r3);
      @(negedge CLK);
    end

    // Async reset mid-read: last vector left RdEn=1 with Valid high and RdData=AA.
    RdEn = 1'b1; WrEn = 1'b0; Address = 4'd0;
    @(posedge CLK);
    #2;
    chk("pre-reset Valid", {7'd0, RdData_Valid}, 8'h01);
    RST = 1'b0;
    #1;
    chk("async RdData", RdData, 8'h00);
    chk("async Valid", {7'd0, RdData_Valid}, 8'h00);
    chk_regs("async", 8'h00, 8'h00, 8'h81, 8'h20);
    @(posedge CLK);
    #1;
    chk("held RdData", RdData, 8'h00);
    chk("held Valid", {7'd0, RdData_Valid}, 8'h00);

    @(negedge CLK);
    RST = 1'b1;
    RdEn = 1'b1; Address = 4'd7;
    @(posedge CLK);
    #1;
    chk("post-reset read7", RdData, 8'h00);
    chk("post-reset Valid", {7'd0, RdData_Valid}, 8'h01);
    @(negedge CLK);
    Address = 4'd15;
    @(posedge CLK);
    #1;
    chk("post-reset read15", RdData, 8'h00);
    @(negedge CLK);
    RdEn = 1'b0;
    @(posedge CLK);
    #1;
    chk("pulse end Valid", {7'd0, RdData_Valid}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
